// File: rtl/shared_pipe_scheduler.sv
// shared_pipe_scheduler
// Shares one fully pipelined, fixed-latency functional unit among NUM_REQ
// elastic requesters. A round-robin arbiter picks one request per advancing
// cycle; a {valid, id} tag pipeline runs in lockstep with the unit and steers
// each result back to the requester that issued it. The whole pipe (tags and
// unit, via unit_ce) stalls only when the tail result cannot be delivered.
// Optional feature: define SHARED_PIPE_SCHED_OCCUPANCY_EN to add the
// in_flight output, a registered count of valid tags in the pipe.
module shared_pipe_scheduler #(
    parameter int NUM_REQ    = 2,
    parameter int LATENCY    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            ins_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] ins_data,
    output logic [NUM_REQ-1:0]            ins_ready,
    output logic [NUM_REQ-1:0]            outs_valid,
    input  logic [NUM_REQ-1:0]            outs_ready,
    output logic [DATA_WIDTH-1:0]         outs_data,
    output logic [DATA_WIDTH-1:0]         unit_operand,
    output logic                          unit_ce,
`ifdef SHARED_PIPE_SCHED_OCCUPANCY_EN
    output logic [$clog2(LATENCY+1)-1:0]  in_flight,
`endif
    input  logic [DATA_WIDTH-1:0]         unit_result
);

    logic [LATENCY-1:0]               tv_q;
    logic [LATENCY-1:0]               tv_d;
    logic [LATENCY-1:0][ID_WIDTH-1:0] tid_q;
    logic [LATENCY-1:0][ID_WIDTH-1:0] tid_d;
    logic [ID_WIDTH-1:0]              ptr_q;
    logic [ID_WIDTH-1:0]              ptr_d;

    logic                tail_v;
    logic [ID_WIDTH-1:0] tail_id;
    logic                adv;
    logic                gnt_v;
    logic [ID_WIDTH-1:0] gnt_id;

    assign tail_v  = tv_q[LATENCY-1];
    assign tail_id = tid_q[LATENCY-1];

    // The pipe moves unless the tail holds a result its owner will not take.
    assign adv     = !tail_v || outs_ready[tail_id];
    assign unit_ce = adv;

    // Round-robin search starting just after the last granted requester;
    // scanning from the farthest offset down leaves the nearest valid one.
    always_comb begin
        logic [ID_WIDTH-1:0] cand;
        gnt_v  = 1'b0;
        gnt_id = ID_WIDTH'((32'(ptr_q) + 32'd1) % NUM_REQ);
        cand   = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = ID_WIDTH'((32'(ptr_q) + 32'(off)) % NUM_REQ);
            if (ins_valid[cand]) begin
                gnt_v  = 1'b1;
                gnt_id = cand;
            end
        end
    end

    assign unit_operand = ins_data[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];

    // Accept only the granted requester, and only when the pipe advances.
    always_comb begin
        ins_ready = '0;
        if (adv && gnt_v) begin
            ins_ready[gnt_id] = 1'b1;
        end
    end

    // The tail tag decides which requester sees the shared result.
    always_comb begin
        outs_valid = '0;
        if (tail_v) begin
            outs_valid[tail_id] = 1'b1;
        end
    end

    assign outs_data = unit_result;

    // Shift the tag pipeline and move the RR pointer on advancing cycles.
    always_comb begin
        tv_d  = tv_q;
        tid_d = tid_q;
        ptr_d = ptr_q;
        if (adv) begin
            tv_d[0]  = gnt_v;
            tid_d[0] = gnt_id;
            for (int k = 1; k < LATENCY; k++) begin
                tv_d[k]  = tv_q[k-1];
                tid_d[k] = tid_q[k-1];
            end
            if (gnt_v) begin
                ptr_d = gnt_id;
            end
        end
    end

    // Tag and pointer state; reset empties the pipe and gives requester 0 first turn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tv_q  <= '0;
            tid_q <= '0;
            ptr_q <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            tv_q  <= tv_d;
            tid_q <= tid_d;
            ptr_q <= ptr_d;
        end
    end

`ifdef SHARED_PIPE_SCHED_OCCUPANCY_EN
    localparam int OCC_W = $clog2(LATENCY+1);

    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    // Count tags entering minus the tag leaving at the tail.
    always_comb begin
        occ_d = occ_q;
        if (adv) begin
            occ_d = occ_q + OCC_W'(gnt_v) - OCC_W'(tail_v);
        end
    end

    // Occupancy register, cleared together with the tags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign in_flight = occ_q;
`endif

endmodule

// File: tb/tb_shared_pipe_scheduler.sv
// tb_shared_pipe_scheduler
// Two instances share one bench: A (3 requesters, latency 4) and B
// (3 requesters, latency 1). Each has its own behavioural unit model, an
// issue-order reference model and a result scoreboard.
// Honours SHARED_PIPE_SCHED_OCCUPANCY_EN when it is defined.
module tb_shared_pipe_scheduler;

    localparam int NR    = 3;
    localparam int DW    = 32;
    localparam int IW    = 2;
    localparam int NI    = 2;
    localparam int LAT_A = 4;
    localparam int LAT_B = 1;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] res;
        int            stamp;
    } fl_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] res;
    } sb_t;

    logic clk = 1'b0;
    logic rst;

    logic [NR-1:0]    ins_valid    [NI];
    logic [NR*DW-1:0] ins_data     [NI];
    logic [NR-1:0]    ins_ready    [NI];
    logic [NR-1:0]    outs_valid   [NI];
    logic [NR-1:0]    outs_ready   [NI];
    logic [DW-1:0]    outs_data    [NI];
    logic [DW-1:0]    unit_operand [NI];
    logic             unit_ce      [NI];
    logic [DW-1:0]    unit_result  [NI];
`ifdef SHARED_PIPE_SCHED_OCCUPANCY_EN
    logic [2:0]       in_flight_a;
    logic [0:0]       in_flight_b;
`endif

    logic [DW-1:0] unit_pipe [NI][LAT_A];

    int  checks = 0;
    int  errors = 0;
    int  rst_epoch = 0;
    fl_t fl_q [NI][$];
    sb_t sb_q [NI][$];
    int  rr_last [NI];
    int  adv_cnt [NI];

    always #5 clk = ~clk;

    shared_pipe_scheduler #(
        .NUM_REQ(NR), .LATENCY(LAT_A), .DATA_WIDTH(DW), .ID_WIDTH(IW)
    ) dut_a (
        .clk(clk), .rst(rst),
        .ins_valid(ins_valid[0]), .ins_data(ins_data[0]), .ins_ready(ins_ready[0]),
        .outs_valid(outs_valid[0]), .outs_ready(outs_ready[0]), .outs_data(outs_data[0]),
        .unit_operand(unit_operand[0]), .unit_ce(unit_ce[0]),
`ifdef SHARED_PIPE_SCHED_OCCUPANCY_EN
        .in_flight(in_flight_a),
`endif
        .unit_result(unit_result[0])
    );

    shared_pipe_scheduler #(
        .NUM_REQ(NR), .LATENCY(LAT_B), .DATA_WIDTH(DW), .ID_WIDTH(IW)
    ) dut_b (
        .clk(clk), .rst(rst),
        .ins_valid(ins_valid[1]), .ins_data(ins_data[1]), .ins_ready(ins_ready[1]),
        .outs_valid(outs_valid[1]), .outs_ready(outs_ready[1]), .outs_data(outs_data[1]),
        .unit_operand(unit_operand[1]), .unit_ce(unit_ce[1]),
`ifdef SHARED_PIPE_SCHED_OCCUPANCY_EN
        .in_flight(in_flight_b),
`endif
        .unit_result(unit_result[1])
    );

    function automatic logic [DW-1:0] unit_fn(input logic [DW-1:0] x);
        return (x * 32'd5) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic int lat_of(input int inst);
        return (inst == 0) ? LAT_A : LAT_B;
    endfunction

    function automatic logic [NR*DW-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    // Behavioural functional units: clock-enabled pipelines of unit_fn.
    always @(posedge clk) begin
        for (int inst = 0; inst < NI; inst++) begin
            if (unit_ce[inst]) begin
                unit_pipe[inst][0] <= unit_fn(unit_operand[inst]);
                for (int k = 1; k < LAT_A; k++) begin
                    unit_pipe[inst][k] <= unit_pipe[inst][k-1];
                end
            end
        end
    end

    assign unit_result[0] = unit_pipe[0][LAT_A-1];
    assign unit_result[1] = unit_pipe[1][LAT_B-1];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs for both instances, then step past the next edge.
    task automatic apply_stimulus(input logic [NR-1:0] v0, input logic [NR-1:0] v1,
                                  input logic [NR-1:0] r0, input logic [NR-1:0] r1,
                                  input logic [NR*DW-1:0] d0, input logic [NR*DW-1:0] d1);
        ins_valid[0]  = v0;
        ins_valid[1]  = v1;
        outs_ready[0] = r0;
        outs_ready[1] = r1;
        ins_data[0]   = d0;
        ins_data[1]   = d1;
        @(posedge clk);
        #1;
    endtask

    // Reference model: requests issue in RR order whenever the pipe advances;
    // a request reaches the tail after LATENCY advancing cycles.
    task automatic model_step(input int inst);
        int            lat_i;
        logic          tail_v;
        logic [IW-1:0] tail_id;
        logic          exp_adv;
        logic          gv;
        int            gid;
        int            cand;
        logic [NR-1:0] exp_ir;
        logic [NR-1:0] exp_ov;
        fl_t           e;
        sb_t           s;
        lat_i   = lat_of(inst);
        tail_v  = 1'b0;
        tail_id = '0;
        if (fl_q[inst].size() > 0) begin
            e = fl_q[inst][0];
            if (adv_cnt[inst] - e.stamp == lat_i) begin
                tail_v  = 1'b1;
                tail_id = e.id;
            end
        end
        exp_ov  = tail_v ? (NR'(1) << tail_id) : '0;
        exp_adv = !tail_v || outs_ready[inst][tail_id];
        gv  = 1'b0;
        gid = 0;
        for (int off = 1; off <= NR; off++) begin
            cand = (rr_last[inst] + off) % NR;
            if (!gv && ins_valid[inst][cand]) begin
                gv  = 1'b1;
                gid = cand;
            end
        end
        exp_ir = (exp_adv && gv) ? (NR'(1) << gid) : '0;
        check_output($sformatf("ins_ready[%0d]", inst), 64'(ins_ready[inst]), 64'(exp_ir));
        check_output($sformatf("unit_ce[%0d]", inst), 64'(unit_ce[inst]), 64'(exp_adv));
        check_output($sformatf("outs_valid[%0d]", inst), 64'(outs_valid[inst]), 64'(exp_ov));
`ifdef SHARED_PIPE_SCHED_OCCUPANCY_EN
        check_output($sformatf("in_flight[%0d]", inst),
                     (inst == 0) ? 64'(in_flight_a) : 64'(in_flight_b),
                     64'(fl_q[inst].size()));
`endif
        if (exp_adv) begin
            if (tail_v) begin
                void'(fl_q[inst].pop_front());
            end
            if (gv) begin
                e.id    = IW'(gid);
                e.res   = unit_fn(ins_data[inst][gid*DW +: DW]);
                e.stamp = adv_cnt[inst];
                fl_q[inst].push_back(e);
                s.id  = e.id;
                s.res = e.res;
                sb_q[inst].push_back(s);
                rr_last[inst] = gid;
            end
            adv_cnt[inst]++;
        end
    endtask

    // Model process: predicts handshakes every cycle and feeds the scoreboard.
    initial begin : model_proc
        int seen_epoch;
        seen_epoch = 0;
        for (int inst = 0; inst < NI; inst++) begin
            rr_last[inst] = NR - 1;
            adv_cnt[inst] = 0;
        end
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rst_epoch != seen_epoch) begin
                    seen_epoch = rst_epoch;
                    for (int inst = 0; inst < NI; inst++) begin
                        fl_q[inst].delete();
                        sb_q[inst].delete();
                        rr_last[inst] = NR - 1;
                    end
                end
                for (int inst = 0; inst < NI; inst++) begin
                    model_step(inst);
                end
            end
        end
    end

    // Monitor: every delivered result must match the oldest expected one.
    initial begin : monitor_proc
        sb_t s;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int inst = 0; inst < NI; inst++) begin
                    if (|(outs_valid[inst] & outs_ready[inst])) begin
                        if (sb_q[inst].size() == 0) begin
                            check_output($sformatf("unexpected_result[%0d]", inst),
                                         64'(outs_valid[inst]), 64'd0);
                        end else begin
                            s = sb_q[inst].pop_front();
                            check_output($sformatf("result_owner[%0d]", inst),
                                         64'(outs_valid[inst]), 64'(NR'(1) << s.id));
                            check_output($sformatf("outs_data[%0d]", inst),
                                         64'(outs_data[inst]), 64'(s.res));
                        end
                    end
                end
            end
        end
    end

    // Stimulus: directed scenarios, random traffic, mid-run reset, drain.
    initial begin : stim_proc
        logic [NR*DW-1:0] d;
        logic [NR-1:0]    r0;
        logic [NR-1:0]    r1;
        rst = 1'b1;
        for (int inst = 0; inst < NI; inst++) begin
            ins_valid[inst]  = '0;
            outs_ready[inst] = '0;
            ins_data[inst]   = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int inst = 0; inst < NI; inst++) begin
            check_output($sformatf("reset_ins_ready[%0d]", inst), 64'(ins_ready[inst]), 64'd0);
            check_output($sformatf("reset_outs_valid[%0d]", inst), 64'(outs_valid[inst]), 64'd0);
            check_output($sformatf("reset_unit_ce[%0d]", inst), 64'(unit_ce[inst]), 64'd1);
        end
        rst = 1'b0;

        // Single request from requester 0 carrying 0x11.
        d = '0;
        d[DW-1:0] = 32'h11;
        apply_stimulus(3'b001, 3'b001, 3'b111, 3'b111, d, d);
        repeat (6) apply_stimulus(3'b000, 3'b000, 3'b111, 3'b111, '0, '0);

        // Requesters 0 and 1 both valid: grants alternate.
        repeat (8) apply_stimulus(3'b011, 3'b011, 3'b111, 3'b111, rand_data(), rand_data());

        // Requester 1 refuses its results for three cycles.
        repeat (3) apply_stimulus(3'b011, 3'b011, 3'b101, 3'b101, rand_data(), rand_data());
        repeat (6) apply_stimulus(3'b011, 3'b011, 3'b111, 3'b111, rand_data(), rand_data());

        // Pointer walk: grant 1, then 101 goes to 2, then to 0.
        apply_stimulus(3'b010, 3'b010, 3'b111, 3'b111, rand_data(), rand_data());
        apply_stimulus(3'b101, 3'b101, 3'b111, 3'b111, rand_data(), rand_data());
        apply_stimulus(3'b101, 3'b101, 3'b111, 3'b111, rand_data(), rand_data());
        repeat (5) apply_stimulus(3'b000, 3'b000, 3'b111, 3'b111, '0, '0);

        // Requester 0 always valid while its result acceptance toggles.
        for (int c = 0; c < 8; c++) begin
            r0 = (c % 2 == 0) ? 3'b001 : 3'b000;
            apply_stimulus(3'b001, 3'b001, r0, r0, rand_data(), rand_data());
        end
        repeat (6) apply_stimulus(3'b000, 3'b000, 3'b111, 3'b111, '0, '0);

        // Random traffic with mostly-ready consumers.
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < NR; b++) begin
                r0[b] = ($urandom_range(0, 3) != 0);
                r1[b] = ($urandom_range(0, 3) != 0);
            end
            apply_stimulus(NR'($urandom_range(0, 7)), NR'($urandom_range(0, 7)),
                           r0, r1, rand_data(), rand_data());
        end
        repeat (8) apply_stimulus(3'b000, 3'b000, 3'b111, 3'b111, '0, '0);

        // Three tags in flight (one at the tail of A), then reset between edges.
        apply_stimulus(3'b111, 3'b111, 3'b111, 3'b111, rand_data(), rand_data());
        apply_stimulus(3'b000, 3'b000, 3'b111, 3'b111, '0, '0);
        apply_stimulus(3'b111, 3'b111, 3'b111, 3'b111, rand_data(), rand_data());
        apply_stimulus(3'b111, 3'b111, 3'b111, 3'b111, rand_data(), rand_data());
        ins_valid[0] = '0;
        ins_valid[1] = '0;
        #1 rst = 1'b1;
        #1;
        for (int inst = 0; inst < NI; inst++) begin
            check_output($sformatf("midreset_outs_valid[%0d]", inst), 64'(outs_valid[inst]), 64'd0);
        end
`ifdef SHARED_PIPE_SCHED_OCCUPANCY_EN
        check_output("midreset_in_flight[0]", 64'(in_flight_a), 64'd0);
        check_output("midreset_in_flight[1]", 64'(in_flight_b), 64'd0);
`endif
        rst_epoch++;
        #1 rst = 1'b0;
        apply_stimulus(3'b111, 3'b111, 3'b111, 3'b111, rand_data(), rand_data());
        repeat (10) apply_stimulus(3'b000, 3'b000, 3'b111, 3'b111, '0, '0);

        // Nothing may remain undelivered after the drain.
        for (int inst = 0; inst < NI; inst++) begin
            check_output($sformatf("undelivered[%0d]", inst), 64'(sb_q[inst].size()), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shared_pipe_scheduler.md
Name: shared_pipe_scheduler

Overview:
- Shares one fully pipelined, fixed-latency functional unit (LATENCY stages, clock-enabled) among NUM_REQ elastic requesters.
- Round-robin arbitration selects one request per advancing cycle and muxes its operand into the unit.
- An internal tag pipeline {valid, requester id} runs in lockstep with the unit and steers each result back to its issuer.
- The whole pipeline stalls only when the result at the tail cannot be delivered.

Parameters:
- NUM_REQ, 2: number of requesters, >= 2.
- LATENCY, 4: unit pipeline depth in stages, >= 1.
- DATA_WIDTH, 32: operand and result width.
- ID_WIDTH, 1: requester index width, equal to max(1, clog2(NUM_REQ)).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- ins_valid  in  NUM_REQ  per-requester request valid.
- ins_data  in  NUM_REQ*DATA_WIDTH  per-requester operand; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ins_ready  out  NUM_REQ  per-requester accept.
- outs_valid  out  NUM_REQ  per-requester result valid.
- outs_ready  in  NUM_REQ  per-requester result accept.
- outs_data  out  DATA_WIDTH  result, shared by all requesters; qualified by outs_valid.
- unit_operand  out  DATA_WIDTH  operand driven into unit stage 0.
- unit_ce  out  1  unit pipeline clock enable.
- unit_result  in  DATA_WIDTH  unit output, aligned with tag stage LATENCY-1.

Behaviour:
- Tag pipeline:
  - Registers tv[0..LATENCY-1] (valid) and tid[0..LATENCY-1] (id); the tail is stage LATENCY-1.
  - Reset (async) sets every tv to 0, every tid to 0, and the RR pointer to NUM_REQ-1, so requester 0 has first priority.
  - After reset all outputs are 0 except unit_ce, which is 1 because the pipe is empty.
- Advance:
  - adv = !tv[LATENCY-1] || outs_ready[tid[LATENCY-1]].
  - unit_ce = adv, combinational.
- Arbitration (combinational, evaluated every cycle):
  - Search from (ptr+1) mod NUM_REQ upward, wrapping, for the first i with ins_valid[i]=1.
  - Result: gnt_v and gnt_id.
  - ins_ready[i] = adv && gnt_v && gnt_id==i.
  - At most one ins_ready bit is high per cycle.
  - unit_operand = ins_data slice gnt_id. When gnt_v=0 it shows slice of ptr+1 (don't-care).
- On a clock edge with adv=1:
  - tv[0] <= gnt_v and tid[0] <= gnt_id.
  - tv[k] <= tv[k-1] and tid[k] <= tid[k-1] for k >= 1.
  - ptr <= gnt_id if gnt_v; otherwise ptr is unchanged.
- On a clock edge with adv=0: all tag stages and ptr hold. A request is never accepted while stalled.
- Delivery:
  - outs_valid[i] = tv[LATENCY-1] && tid[LATENCY-1]==i.
  - outs_data = unit_result.
  - The result is held stable while stalled, because the unit is also stalled via unit_ce.
- Latency: a request accepted in cycle t (ins_valid && ins_ready) shows outs_valid in cycle t+LATENCY, provided no stall occurs. Each stall cycle adds one cycle.
- Throughput: one issue per cycle. Back-to-back issues from different requesters interleave according to the RR order.
- Simultaneous events: tail delivery and new issue in the same cycle are normal operation (adv=1). A stall blocks issue even when the pipe has bubbles; bubbles are not compressed.
- LATENCY=1: stage 0 is the tail. adv depends only on the current tail.
- Reset asserted mid-operation: in-flight tags are dropped immediately and asynchronously; outs_valid falls without waiting for a clock edge.
- Combinational paths: outs_ready to ins_ready and unit_ce. ins_valid does not feed adv.

Optional Feature:
- Macro: SHARED_PIPE_SCHED_OCCUPANCY_EN.
- When defined:
  - Adds output in_flight, width clog2(LATENCY+1).
  - in_flight is a registered count of set tv bits.
  - Reset value 0.
  - On an advancing edge it updates by +gnt_v and -(tv tail delivered). It holds when not advancing.
  - The bench compares in_flight against popcount(tv) every cycle.
- When undefined: no port, no counter logic; all other behaviour identical.

Test Plan:
- Single requester, LATENCY=4, all outs_ready=1: req 0 issues 0x11 in cycle 2 -> outs_valid[0] in cycle 6, outs_data = unit(0x11), outs_valid[1]=0.
- Both requesters valid continuously, outs_ready=11 -> grants alternate 0,1,0,1; ins_ready is one-hot every cycle; results return in the same order, each LATENCY cycles after issue.
- Tail belongs to req 1 with outs_ready[1]=0 for 3 cycles -> unit_ce=0 and ins_ready=00 for 3 cycles; tag and outs_data stable; delivery and issue resume on the cycle outs_ready[1]=1.
- NUM_REQ=3, ptr=1, ins_valid=101 -> req 2 granted, ptr becomes 2; next grant goes to req 0.
- Pipe holding 3 in-flight tags, rst pulsed between edges -> outs_valid=000 immediately; after release, first grant goes to req 0; with the macro defined, in_flight=0.
- LATENCY=1, req 0 issues every cycle with outs_ready[0] toggling 1,0,1 -> accepts only in cycles where outs_ready[0]=1 or the tail is empty; no result lost or duplicated.
